// File: rtl/decryption_module.sv
// Iterative decryptor for a rotate/XOR round cipher: one inverse round per clock, fixed latency.
// Optional DEC_PARITY_EN adds a cipher_par input checked at accept; a mismatch yields out_err=1, data_out=0.
module decryption_module #(
    parameter int N      = 8,
    parameter int ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] cipher_in,
    input  logic [N-1:0] key,
`ifdef DEC_PARITY_EN
    input  logic         cipher_par,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         out_err,
    output logic         busy
);

    localparam int CW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  key_q, key_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef DEC_PARITY_EN
    logic          err_q, err_d;
`endif

    function automatic logic [N-1:0] rotl_n(input logic [N-1:0] v, input int s);
        logic [N-1:0] r;
        int           m;
        r = v;
        m = s % N;
        for (int i = 0; i < N; i++) begin
            if (i < m) r = {r[N-2:0], r[N-1]};
        end
        return r;
    endfunction

    function automatic logic [N-1:0] rotr1(input logic [N-1:0] v);
        return {v[0], v[N-1:1]};
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
`ifdef DEC_PARITY_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    x_d     = cipher_in;
                    key_d   = key;
                    cnt_d   = '0;
`ifdef DEC_PARITY_EN
                    err_d   = (cipher_par != ^cipher_in);
`endif
                end
            end
            RUN: begin
                // Counter walks 0..ROUNDS; rounds are applied in reverse order, r = ROUNDS-1-cnt.
                if (cnt_q == CW'(ROUNDS)) begin
                    state_d = DONE;
                end else begin
                    x_d   = rotr1(x_q) ^ rotl_n(key_q, ROUNDS - 1 - int'(cnt_q));
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
`ifdef DEC_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
`ifdef DEC_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // Outputs are masked outside DONE so intermediate round values never escape.
`ifdef DEC_PARITY_EN
    assign out_err  = out_valid & err_q;
    assign data_out = (out_valid && !err_q) ? x_q : '0;
`else
    assign out_err  = 1'b0;
    assign data_out = out_valid ? x_q : '0;
`endif

endmodule

// File: tb/tb_decryption_module.sv
// Bench for decryption_module (N=8, ROUNDS=4): directed scenarios plus random jobs checked
// against the forward cipher; the parity scenario runs only when DEC_PARITY_EN is defined.
module tb_decryption_module;
    localparam int N      = 8;
    localparam int ROUNDS = 4;
    localparam int LAT    = ROUNDS + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] cipher_in = '0;
    logic [N-1:0] key = '0;
    logic         cipher_par = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] data_out;
    logic         out_err;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    decryption_module #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher_in (cipher_in),
        .key       (key),
`ifdef DEC_PARITY_EN
        .cipher_par(cipher_par),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_err   (out_err),
        .busy      (busy)
    );

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
        logic [2*N-1:0] t;
        t = {v, v} << (s % N);
        return t[2*N-1:N];
    endfunction

    // Forward cipher: x = rotl(x ^ rotl(key, r), 1) for r = 0..ROUNDS-1.
    function automatic logic [N-1:0] encrypt(input logic [N-1:0] p, input logic [N-1:0] k);
        logic [N-1:0] x;
        x = p;
        for (int r = 0; r < ROUNDS; r++) x = rotl(x ^ rotl(k, r), 1);
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one job, optionally scramble inputs while it runs, and wait (bounded) for out_valid.
    task automatic drive_job(input logic [N-1:0] c, input logic [N-1:0] k, input logic bad_par,
                             input logic scramble, output int lat, output int leaks);
        in_valid   = 1'b1;
        cipher_in  = c;
        key        = k;
        cipher_par = (^c) ^ bad_par;
        tick();
        in_valid = 1'b0;
        lat   = 0;
        leaks = 0;
        while (!out_valid && lat < 50) begin
            if (data_out !== '0 || in_ready !== 1'b0 || busy !== 1'b1) leaks++;
            if (scramble) begin
                in_valid  = 1'($urandom_range(0, 1));
                key       = N'($urandom);
                cipher_in = N'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if ({in_ready, out_valid, data_out, out_err, busy} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL reset_outputs: got rdy=%b vld=%b dout=%h err=%b busy=%b, want 1 0 00 0 0",
                     in_ready, out_valid, data_out, out_err, busy);
        end else pass_cnt++;
        total_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, leaks;
        out_ready = 1'b1;
        drive_job(8'h5A, 8'h00, 1'b0, 1'b0, lat, leaks);
        if (lat !== LAT) begin
            $display("FAIL s1_latency: got %0d want %0d", lat, LAT);
        end else pass_cnt++;
        total_cnt++;
        if (data_out !== 8'hA5 || out_err !== 1'b0) begin
            $display("FAIL s1_data: got %h err=%b want a5 err=0", data_out, out_err);
        end else pass_cnt++;
        total_cnt++;
        if (leaks !== 0) begin
            $display("FAIL s1_run_outputs: %0d bad cycles, want 0", leaks);
        end else pass_cnt++;
        total_cnt++;
        tick();
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== '0) begin
            $display("FAIL s1_release: got rdy=%b vld=%b dout=%h want 1 0 00", in_ready, out_valid, data_out);
        end else pass_cnt++;
        total_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_keys();
        int lat1, lat2, leaks;
        logic [N-1:0] d1;
        out_ready = 1'b1;
        drive_job(8'h10, 8'h01, 1'b0, 1'b0, lat1, leaks);
        d1 = data_out;
        tick();
        drive_job(8'h00, 8'hFF, 1'b0, 1'b0, lat2, leaks);
        if (d1 !== 8'h01) begin
            $display("FAIL s2_key01: got %h want 01", d1);
        end else pass_cnt++;
        total_cnt++;
        if (data_out !== 8'h00 || lat2 !== lat1 || lat1 !== LAT) begin
            $display("FAIL s2_keyff: got %h lat %0d/%0d want 00 lat %0d", data_out, lat1, lat2, LAT);
        end else pass_cnt++;
        total_cnt++;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, leaks, bad;
        logic [N-1:0] p, k;
        p = N'($urandom);
        k = N'($urandom);
        drive_job(encrypt(p, k), k, 1'b0, 1'b0, lat, leaks);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            cipher_in = N'($urandom);
            key       = N'($urandom);
            if (data_out !== p || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            tick();
        end
        in_valid = 1'b0;
        if (bad !== 0) begin
            $display("FAIL s3_hold: %0d unstable cycles (last dout=%h want %h)", bad, data_out, p);
        end else pass_cnt++;
        total_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL s3_release: got rdy=%b busy=%b vld=%b want 1 0 0", in_ready, busy, out_valid);
        end else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_reset_abort();
        int lat, leaks, seen;
        logic [N-1:0] p, k;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cipher_in = 8'h5A;
        key       = 8'h3C;
        cipher_par = ^cipher_in;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        if ({in_ready, out_valid, data_out, out_err, busy} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL s4_abort: got rdy=%b vld=%b dout=%h err=%b busy=%b, want 1 0 00 0 0",
                     in_ready, out_valid, data_out, out_err, busy);
        end else pass_cnt++;
        total_cnt++;
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        if (seen !== 0) begin
            $display("FAIL s4_no_result: %0d cycles with activity, want 0", seen);
        end else pass_cnt++;
        total_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p = 8'hC3;
        k = 8'h96;
        drive_job(encrypt(p, k), k, 1'b0, 1'b0, lat, leaks);
        if (data_out !== p || lat !== LAT) begin
            $display("FAIL s4_recover: got %h lat %0d want %h lat %0d", data_out, lat, p, LAT);
        end else pass_cnt++;
        total_cnt++;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef DEC_PARITY_EN
    task automatic test_parity();
        int lat, leaks;
        out_ready = 1'b1;
        in_valid   = 1'b1;
        cipher_in  = 8'h5A;
        key        = 8'h00;
        cipher_par = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        if (out_valid !== 1'b1 || out_err !== 1'b1 || data_out !== 8'h00) begin
            $display("FAIL s5_bad_par: got vld=%b err=%b dout=%h want 1 1 00", out_valid, out_err, data_out);
        end else pass_cnt++;
        total_cnt++;
        tick();
        drive_job(8'h5A, 8'h00, 1'b0, 1'b0, lat, leaks);
        if (out_err !== 1'b0 || data_out !== 8'hA5 || lat !== LAT) begin
            $display("FAIL s5_good_par: got err=%b dout=%h lat %0d want 0 a5 %0d", out_err, data_out, lat, LAT);
        end else pass_cnt++;
        total_cnt++;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        int lat, leaks;
        logic [N-1:0] p, k;
        for (int j = 0; j < 10; j++) begin
            p = N'($urandom);
            k = N'($urandom);
            drive_job(encrypt(p, k), k, 1'b0, 1'b1, lat, leaks);
            if (data_out !== p || lat !== LAT || leaks !== 0 || out_err !== 1'b0) begin
                $display("FAIL s6_job%0d: got %h lat %0d leaks %0d err %b want %h lat %0d leaks 0 err 0",
                         j, data_out, lat, leaks, out_err, p, LAT);
            end else pass_cnt++;
            total_cnt++;
            repeat ($urandom_range(0, 2)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_keys();
        test_backpressure();
        test_reset_abort();
`ifdef DEC_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
